bomb_controller: RTL and testbench
==================================

Name: bomb_controller

Overview:
Game core for the bomb-dismantlement game. Arms a countdown, collects 4-digit code entries from the keypad debouncer, and compares each entry against the secret code. Drives the level-held `success` / `fail` indications consumed by the end-of-game display blocks. Returns to idle when those display blocks pulse `repeat_rst` after their display interval.

Parameters:
- CODE, 16'h1234: secret code as 4 BCD digits, most significant digit entered first.
- TICK_DIV, 50000000: clk cycles per one-second countdown tick (≥2).
- START_SECS, 60: countdown reload value in seconds (1..99).
- MAX_TRIES, 3: wrong entries allowed before fail (1..3).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- arm  input  1  single-cycle pulse; starts the game from IDLE.
- digit  input  4  BCD key value; valid only with digit_stb.
- digit_stb  input  1  single-cycle pulse; one debounced keypress.
- repeat_rst  input  1  restart request from the display blocks; sampled as a level.
- success  output  1  high while in state WIN.
- fail  output  1  high while in state LOSE.
- armed  output  1  high while in state RUN.
- secs_bcd  output  8  remaining seconds as two BCD digits, tens in [7:4].
- tries_left  output  2  remaining wrong entries allowed.
- digit_cnt  output  3  digits collected in the current entry (0..3).

Behaviour:
- Reset values (async, rst_n=0):
  - State IDLE; success=0, fail=0, armed=0.
  - secs_bcd = BCD(START_SECS); tries_left = MAX_TRIES; digit_cnt = 0.
  - Entry shift register = 0; prescaler = 0.
- States and transitions:
  - IDLE: digits ignored. arm → RUN next cycle. On entry to RUN: prescaler = 0, digit_cnt = 0, secs_bcd reloaded, tries_left reloaded.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1. On wrap, secs_bcd decrements by one, with BCD borrow (10 → 09, 00 never decremented).
    - On digit_stb, digit is shifted into the 16-bit entry register from the low nibble and digit_cnt increments.
    - On the 4th strobe the full entry, including the current digit, is compared to CODE in that same cycle:
      - Match → WIN.
      - Mismatch with tries_left=1 → LOSE; tries_left becomes 0.
      - Mismatch otherwise → tries_left decrements, digit_cnt = 0, stay in RUN.
    - Tick arriving while secs_bcd=01 → secs_bcd = 00 and LOSE.
  - WIN / LOSE:
    - Counter, entry register and secs_bcd are frozen.
    - digit_stb and arm are ignored.
    - repeat_rst=1 → IDLE next cycle; secs_bcd and tries_left reload, digit_cnt = 0.
- Output timing: all outputs are registered and decoded from the current state. success, fail and armed change on the cycle after the causing event (1-cycle latency).
- Precedence in a single cycle:
  - Correct 4th digit together with the final tick → WIN; secs_bcd still updates to 00.
  - Wrong last-try entry together with the final tick → LOSE.
  - repeat_rst is ignored in IDLE and RUN.
  - arm is ignored outside IDLE.
- Digit values above 9 are accepted and compared as raw nibbles; they can never match a valid BCD CODE.
- Reset asserted mid-game returns everything to reset values immediately, regardless of state.

Test Plan:
Bench uses TICK_DIV=4, START_SECS=5, MAX_TRIES=3, CODE=16'h1234.

1. Reset, pulse arm, strobe digits 1,2,3,4 → armed=1 the cycle after arm. success=1 the cycle after the 4th strobe; armed=0; tries_left=3; secs_bcd frozen at its value.
2. Arm, enter 1,2,3,5 → digit_cnt back to 0, tries_left=2, still armed. Then enter 1,2,3,4 → success=1.
3. Arm, enter three wrong codes → tries_left 3→2→1→0. fail=1 the cycle after the 12th strobe.
4. Arm, no keys → secs_bcd steps 05,04,03,02,01 every 4 cycles. At the 5th tick secs_bcd=00 and fail=1 the next cycle. Hold 20 more cycles → values unchanged.
5. Arm, time the 4th correct digit to coincide with the final tick → success=1, fail=0, secs_bcd=00.
6. From WIN, pulse repeat_rst → IDLE: success=0, secs_bcd=05, tries_left=3. Also:
   - Strobes without arm → digit_cnt stays 0.
   - rst_n low mid-RUN → all outputs at reset values immediately.

Source files
------------

// File: rtl/bomb_controller.sv
// Bomb-game core: runs a BCD countdown, collects 4-digit keypad entries and
// compares each entry with the secret code, holding the win/lose result until restarted.
module bomb_controller #(
    parameter logic [15:0] CODE       = 16'h1234,
    parameter int          TICK_DIV   = 50000000,
    parameter int          START_SECS = 60,
    parameter int          MAX_TRIES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic [3:0] digit,
    input  logic       digit_stb,
    input  logic       repeat_rst,
    output logic       success,
    output logic       fail,
    output logic       armed,
    output logic [7:0] secs_bcd,
    output logic [1:0] tries_left,
    output logic [2:0] digit_cnt
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [7:0]      SECS_INIT  = 8'(((START_SECS / 10) * 16) + (START_SECS % 10));
    localparam logic [1:0]      TRIES_INIT = 2'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, RUN, WIN, LOSE} state_t;

    state_t        state;
    logic [15:0]   entry;
    logic [PW-1:0] presc;

    logic       tick;
    logic       last_digit;
    logic       code_ok;
    logic       last_sec;
    logic       out_of_tries;
    logic [7:0] secs_dec;

    assign tick         = (presc == TICK_LAST);
    assign last_digit   = digit_stb && (digit_cnt == 3'd3);
    // the entry compared includes the digit arriving this cycle
    assign code_ok      = ({entry[11:0], digit} == CODE);
    assign last_sec     = (secs_bcd == 8'h01);
    assign out_of_tries = (tries_left == 2'd1);

    // BCD decrement with borrow; 00 holds
    always_comb begin
        secs_dec = secs_bcd;
        if (secs_bcd != 8'h00) begin
            if (secs_bcd[3:0] == 4'd0)
                secs_dec = {secs_bcd[7:4] - 4'd1, 4'd9};
            else
                secs_dec = {secs_bcd[7:4], secs_bcd[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            success    <= 1'b0;
            fail       <= 1'b0;
            armed      <= 1'b0;
            secs_bcd   <= SECS_INIT;
            tries_left <= TRIES_INIT;
            digit_cnt  <= 3'd0;
            entry      <= 16'h0000;
            presc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state      <= RUN;
                        armed      <= 1'b1;
                        presc      <= '0;
                        digit_cnt  <= 3'd0;
                        secs_bcd   <= SECS_INIT;
                        tries_left <= TRIES_INIT;
                        entry      <= 16'h0000;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick)
                        secs_bcd <= secs_dec;
                    if (digit_stb) begin
                        entry     <= {entry[11:0], digit};
                        digit_cnt <= last_digit ? 3'd0 : digit_cnt + 3'd1;
                    end
                    if (last_digit && !code_ok)
                        tries_left <= tries_left - 2'd1;
                    // a correct code beats a simultaneous timeout
                    if (last_digit && code_ok) begin
                        state   <= WIN;
                        armed   <= 1'b0;
                        success <= 1'b1;
                    end else if ((last_digit && out_of_tries) || (tick && last_sec)) begin
                        state <= LOSE;
                        armed <= 1'b0;
                        fail  <= 1'b1;
                    end
                end
                WIN, LOSE: begin
                    if (repeat_rst) begin
                        state      <= IDLE;
                        success    <= 1'b0;
                        fail       <= 1'b0;
                        secs_bcd   <= SECS_INIT;
                        tries_left <= TRIES_INIT;
                        digit_cnt  <= 3'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_controller.sv
// Directed plus random stimulus for bomb_controller, checked every cycle against
// a decimal/queue model of the game rules.
module tb_bomb_controller;

    localparam logic [15:0] CODE  = 16'h1234;
    localparam int          TDIV  = 4;
    localparam int          START = 5;
    localparam int          MAXT  = 3;

    localparam int M_IDLE = 0, M_RUN = 1, M_WIN = 2, M_LOSE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digit_stb = 1'b0;
    logic       repeat_rst = 1'b0;
    logic       success, fail, armed;
    logic [7:0] secs_bcd;
    logic [1:0] tries_left;
    logic [2:0] digit_cnt;

    int vectors = 0;
    int miscompares = 0;

    int m_state, m_secs, m_tries, m_run;
    int m_q[$];

    bomb_controller #(.CODE(CODE), .TICK_DIV(TDIV), .START_SECS(START), .MAX_TRIES(MAXT)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .digit(digit), .digit_stb(digit_stb),
        .repeat_rst(repeat_rst), .success(success), .fail(fail), .armed(armed),
        .secs_bcd(secs_bcd), .tries_left(tries_left), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_secs  = START;
        m_tries = MAXT;
        m_run   = 0;
        m_q.delete();
    endtask

    task automatic model_update(input bit a, input bit s, input int d, input bit r);
        int  nxt;
        int  code;
        bit  tick;
        case (m_state)
            M_IDLE: if (a) begin
                model_reset();
                m_state = M_RUN;
            end
            M_RUN: begin
                tick = ((m_run % TDIV) == TDIV - 1);
                m_run++;
                nxt = M_RUN;
                if (s) begin
                    m_q.push_back(d);
                    if (m_q.size() == 4) begin
                        code = (m_q[0] << 12) | (m_q[1] << 8) | (m_q[2] << 4) | m_q[3];
                        if (code == int'(CODE)) nxt = M_WIN;
                        else begin
                            m_tries--;
                            if (m_tries == 0) nxt = M_LOSE;
                        end
                        m_q.delete();
                    end
                end
                if (tick && m_secs > 0) begin
                    m_secs--;
                    if (m_secs == 0 && nxt != M_WIN) nxt = M_LOSE;
                end
                m_state = nxt;
            end
            default: if (r) begin
                m_state = M_IDLE;
                m_secs  = START;
                m_tries = MAXT;
                m_q.delete();
            end
        endcase
    endtask

    function automatic logic [31:0] exp_vec();
        logic [7:0] sb;
        sb = 8'(((m_secs / 10) * 16) + (m_secs % 10));
        return {16'h0, m_state == M_WIN, m_state == M_LOSE, m_state == M_RUN,
                sb, 2'(m_tries), 3'(m_q.size())};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {16'h0, success, fail, armed, secs_bcd, tries_left, digit_cnt};
    endfunction

    task automatic step(input bit a, input bit s, input logic [3:0] d, input bit r);
        arm = a; digit_stb = s; digit = d; repeat_rst = r;
        @(posedge clk); #1;
        model_update(a, s, int'(d), r);
        arm = 1'b0; digit_stb = 1'b0; repeat_rst = 1'b0;
        chk("cycle", obs_vec(), exp_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0);
    endtask

    task automatic key(input logic [3:0] d);
        step(0, 1, d, 0);
    endtask

    task automatic enter(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) key(4'((c >> (4 * i)) & 16'hF));
    endtask

    initial begin
        logic [3:0] rd;
        int pos;
        model_reset();
        #12;
        chk("rst_vec", obs_vec(), {16'h0, 3'b000, 8'h05, 2'd3, 3'd0});
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst", obs_vec(), exp_vec());

        // 1: straight win
        step(1, 0, 4'd0, 0);
        chk("t1_armed", armed, 1);
        key(4'd1); key(4'd2); key(4'd3);
        chk("t1_cnt3", digit_cnt, 3);
        key(4'd4);
        chk("t1_success", success, 1);
        chk("t1_armed0", armed, 0);
        chk("t1_tries", tries_left, 3);
        chk("t1_secs", secs_bcd, 8'h04);
        idle(6);
        chk("t1_frozen", secs_bcd, 8'h04);
        // 6: restart from WIN, then keys in IDLE are ignored
        step(0, 0, 4'd0, 1);
        chk("t6_success0", success, 0);
        chk("t6_secs", secs_bcd, 8'h05);
        chk("t6_tries", tries_left, 3);
        key(4'd1); key(4'd2);
        chk("t6_idle_cnt", digit_cnt, 0);
        step(1, 0, 4'd0, 1);
        chk("t6_rr_in_run", armed, 1);

        // 2: one wrong entry then correct
        enter(16'h1235);
        chk("t2_cnt0", digit_cnt, 0);
        chk("t2_tries", tries_left, 2);
        chk("t2_armed", armed, 1);
        enter(16'h1234);
        chk("t2_success", success, 1);
        step(0, 0, 4'd0, 1);

        // 3: three wrong entries
        step(1, 0, 4'd0, 0);
        enter(16'h9999);
        chk("t3_tries2", tries_left, 2);
        enter(16'hF234);
        chk("t3_tries1", tries_left, 1);
        chk("t3_fail_early", fail, 0);
        enter(16'h4321);
        chk("t3_tries0", tries_left, 0);
        chk("t3_fail", fail, 1);
        step(0, 0, 4'd0, 1);

        // 4: timeout
        step(1, 0, 4'd0, 0);
        for (int k = 1; k <= 5; k++) begin
            idle(3);
            chk("t4_before_tick", fail, 0);
            idle(1);
            chk("t4_secs", secs_bcd, 8'(5 - k));
        end
        chk("t4_fail", fail, 1);
        chk("t4_armed0", armed, 0);
        idle(20);
        chk("t4_hold_secs", secs_bcd, 8'h00);
        chk("t4_hold_fail", fail, 1);
        step(1, 1, 4'd1, 0);
        chk("t4_arm_ignored", fail, 1);
        step(0, 0, 4'd0, 1);

        // 5: correct last digit on the final tick
        step(1, 0, 4'd0, 0);
        idle(16);
        key(4'd1); key(4'd2); key(4'd3);
        chk("t5_secs01", secs_bcd, 8'h01);
        key(4'd4);
        chk("t5_success", success, 1);
        chk("t5_fail0", fail, 0);
        chk("t5_secs00", secs_bcd, 8'h00);
        step(0, 0, 4'd0, 1);

        // async reset mid-RUN
        step(1, 0, 4'd0, 0);
        idle(5);
        key(4'd7); key(4'd8);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_mid_run", obs_vec(), {16'h0, 3'b000, 8'h05, 2'd3, 3'd0});
        #3;
        rst_n = 1'b1;
        idle(2);

        // random traffic, digits biased toward the code so wins occur
        for (int i = 0; i < 3000; i++) begin
            pos = m_q.size();
            if ($urandom_range(0, 3) != 0) rd = 4'((CODE >> (12 - 4 * pos)) & 16'hF);
            else rd = 4'($urandom_range(0, 15));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, rd,
                 $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
